clk_gate_ctrl: RTL and testbench
================================

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 Parameter N_REQ, 4, number of clock requesters (1..8).
REQ-002 Parameter WAKE_CYC, 2, cycles clk_out runs before the first ack (1..15).
REQ-003 Parameter IDLE_CYC, 8, cycles with no request before gating off (1..15).
REQ-004 Port clk_in  input  1  free-running source clock; sole clock of the block.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port req  input  N_REQ  per-requester clock request, level, synchronous to clk_in.
REQ-007 Port force_on  input  1  debug override; keeps the clock enabled while high.
REQ-008 Port ack  output  N_REQ  per-requester grant: the clock is stable for that requester.
REQ-009 Port clk_out  output  1  gated clock, glitch-free.
REQ-010 Port clk_en  output  1  registered gate enable, observable copy.
REQ-011 Port state_o  output  2  current FSM state encoding.

Function
REQ-012 The FSM SHALL have four states: OFF=0, WAKE=1, ON=2, IDLE_WAIT=3.
REQ-013 The FSM SHALL move from OFF to WAKE on the first edge where any_req = |req | force_on is 1, and SHALL load the counter with WAKE_CYC-1.
REQ-014 In WAKE, clk_en SHALL be 1 and ack SHALL be all-zero; the counter SHALL decrement each cycle; at 0 the FSM SHALL go to ON if any_req, else to IDLE_WAIT.
REQ-015 In ON, ack[i] SHALL equal req[i] registered (1-cycle latency), and clk_en SHALL be 1.
REQ-016 The FSM SHALL move from ON to IDLE_WAIT when any_req is 0, and SHALL load the counter with IDLE_CYC-1.
REQ-017 In IDLE_WAIT, clk_en SHALL stay 1, ack SHALL be zero, and the counter SHALL decrement each cycle.
REQ-018 In IDLE_WAIT, if any_req is 1 the FSM SHALL return to ON on the next edge with no wake delay, and ack SHALL follow one cycle later.
REQ-019 When the counter is 0 and any_req is 0, the FSM SHALL go to OFF and clk_en SHALL deassert on the same edge.
REQ-020 When a request and idle expiry occur on the same edge, the request SHALL win and the FSM SHALL go to ON.
REQ-021 The counter SHALL be CNT_W=4 bits; it SHALL saturate at 0 and never wrap.
REQ-022 A req[i] drop in ON SHALL clear ack[i] on the next edge, independent of other requesters.
REQ-023 clk_out SHALL be clk_in AND a low-transparent latch of clk_en, so clk_out never truncates a high phase.
REQ-024 force_on SHALL behave as an extra requester with no ack bit.

Reset
REQ-025 With rst_n low, the block SHALL immediately set state=OFF, counter=0, clk_en=0, ack=0, and the gate latch enable to 0; clk_out SHALL be held low.
REQ-026 Reset asserted mid-operation SHALL abort any state with no completion handshake.
REQ-027 After reset deassertion, the block SHALL evaluate req from the first clk_in rising edge.

Structure
REQ-028 The package clk_gate_pkg SHALL hold the state enum (OFF/WAKE/ON/IDLE_WAIT), CNT_W, and the WAKE_CYC/IDLE_CYC range limits.
REQ-029 A single sub-module, clock_gate_cell (ports clk_in, en, rst_n, clk_out), SHALL implement the latch-AND gate; the FSM and counter SHALL stay in clk_gate_ctrl.
REQ-030 Out-of-range parameters SHALL cause an elaboration-time error.

Verification
REQ-031 Reset then req=4'b0001 held -> WAKE for 2 cycles with clk_en=1, ack=0; ON next; ack=4'b0001 one cycle after entering ON.
REQ-032 req drops to 0 in ON -> IDLE_WAIT for 8 cycles with clk_en=1, then OFF; clk_out shows no pulse afterwards and no runt pulse at the gating edge.
REQ-033 req[2] rises at IDLE_WAIT count 3 -> ON next edge (no WAKE); ack=4'b0100 one cycle later.
REQ-034 req rises on the exact edge the idle counter hits 0 -> FSM goes to ON, clk_en never deasserts.
REQ-035 rst_n pulsed low in ON with ack=4'b1010 -> ack, clk_en, and clk_out go low asynchronously; state_o=0; a full WAKE sequence is required after release.
REQ-036 force_on=1 with req=0 from reset -> WAKE then ON with ack=0 and the clock running; force_on=0 -> IDLE_WAIT then OFF after 8 cycles.

Source files
------------

// File: rtl/clk_gate_pkg.sv
// Shared types and limits for the clock-gate controller: FSM state encoding,
// counter width and the legal ranges of the timing parameters.
package clk_gate_pkg;

    localparam int CNT_W = 4;

    localparam int N_REQ_MIN    = 1;
    localparam int N_REQ_MAX    = 8;
    localparam int WAKE_CYC_MIN = 1;
    localparam int WAKE_CYC_MAX = 15;
    localparam int IDLE_CYC_MIN = 1;
    localparam int IDLE_CYC_MAX = 15;

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        WAKE      = 2'd1,
        ON        = 2'd2,
        IDLE_WAIT = 2'd3
    } state_e;

endpackage

// File: rtl/clock_gate_cell.sv
// Glitch-free clock gate: enable is captured by a latch that is transparent
// only while clk_in is low, then ANDed with clk_in.
module clock_gate_cell (
    input  logic clk_in,
    input  logic en,
    input  logic rst_n,
    output logic clk_out
);

    logic en_lat;

    // Enable can only change while clk_in is low, so a high phase is never cut short.
    always_latch begin
        if (!rst_n) begin
            en_lat <= 1'b0;
        end else if (!clk_in) begin
            en_lat <= en;
        end
    end

    assign clk_out = clk_in & en_lat;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Request-driven clock gate controller: wakes the gated clock for WAKE_CYC
// cycles before granting, and gates it off after IDLE_CYC request-free cycles.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WAKE_CYC = 2,
    parameter int IDLE_CYC = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             force_on,
    output logic [N_REQ-1:0] ack,
    output logic             clk_out,
    output logic             clk_en,
    output logic [1:0]       state_o
);

    if (N_REQ < N_REQ_MIN || N_REQ > N_REQ_MAX) begin : g_bad_n_req
        $error("clk_gate_ctrl: N_REQ out of range");
    end
    if (WAKE_CYC < WAKE_CYC_MIN || WAKE_CYC > WAKE_CYC_MAX) begin : g_bad_wake
        $error("clk_gate_ctrl: WAKE_CYC out of range");
    end
    if (IDLE_CYC < IDLE_CYC_MIN || IDLE_CYC > IDLE_CYC_MAX) begin : g_bad_idle
        $error("clk_gate_ctrl: IDLE_CYC out of range");
    end

    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYC - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               clk_en_q, clk_en_d;

    logic               any_req;
    logic               cnt_zero;
    logic [CNT_W-1:0]   cnt_dec;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= OFF;
            cnt_q    <= '0;
            ack_q    <= '0;
            clk_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            clk_en_q <= clk_en_d;
        end
    end

    always_comb begin
        any_req  = (|req) | force_on;
        cnt_zero = (cnt_q == '0);
        cnt_dec  = cnt_zero ? '0 : cnt_q - CNT_W'(1);
        state_d  = state_q;
        cnt_d    = cnt_q;
        ack_d    = '0;

        case (state_q)
            OFF: begin
                if (any_req) begin
                    state_d = WAKE;
                    cnt_d   = WAKE_LOAD;
                end
            end
            WAKE: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_dec;
                end else if (any_req) begin
                    state_d = ON;
                end else begin
                    state_d = IDLE_WAIT;
                    cnt_d   = IDLE_LOAD;
                end
            end
            ON: begin
                ack_d = req;
                if (!any_req) begin
                    state_d = IDLE_WAIT;
                    cnt_d   = IDLE_LOAD;
                end
            end
            IDLE_WAIT: begin
                // A request arriving on the expiry edge keeps the clock running.
                if (any_req) begin
                    state_d = ON;
                end else if (cnt_zero) begin
                    state_d = OFF;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            default: begin
                state_d = OFF;
            end
        endcase

        clk_en_d = (state_d != OFF);
    end

    clock_gate_cell u_gate (
        .clk_in  (clk_in),
        .en      (clk_en_q),
        .rst_n   (rst_n),
        .clk_out (clk_out)
    );

    assign ack     = ack_q;
    assign clk_en  = clk_en_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: directed vector table, corner-case sequences and
// random request traffic checked against a phase/elapsed-time reference model.
module tb_clk_gate_ctrl;

    localparam int N_REQ    = 4;
    localparam int WAKE_CYC = 2;
    localparam int IDLE_CYC = 8;

    localparam int P_OFF  = 0;
    localparam int P_WAKE = 1;
    localparam int P_ON   = 2;
    localparam int P_IDLE = 3;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic [N_REQ-1:0] req;
    logic             force_on;
    logic [N_REQ-1:0] ack;
    logic             clk_out;
    logic             clk_en;
    logic [1:0]       state_o;

    clk_gate_ctrl #(
        .N_REQ    (N_REQ),
        .WAKE_CYC (WAKE_CYC),
        .IDLE_CYC (IDLE_CYC)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .req      (req),
        .force_on (force_on),
        .ack      (ack),
        .clk_out  (clk_out),
        .clk_en   (clk_en),
        .state_o  (state_o)
    );

    // ---------------- clock ----------------
    always #5 clk_in = ~clk_in;

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    int rise_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Gated clock edges must coincide with source clock edges.
    always @(posedge clk_out) begin
        if (rst_n === 1'b1) begin
            rise_cnt++;
            chk("clk_out_rise_aligned", clk_in, 1);
        end
    end

    always @(negedge clk_out) begin
        if (rst_n === 1'b1) chk("clk_out_no_runt", clk_in, 0);
    end

    // ---------------- reference model ----------------
    // Tracks which phase the controller is in and how many cycles it has
    // spent there, then compares against the configured durations.
    int               m_phase;
    int               m_elapsed;
    logic [N_REQ-1:0] m_ack;

    task automatic model_reset();
        m_phase   = P_OFF;
        m_elapsed = 0;
        m_ack     = '0;
    endtask

    task automatic model_update();
        logic any_r;
        any_r = (|req) | force_on;
        m_ack = (m_phase == P_ON) ? req : '0;
        case (m_phase)
            P_OFF: begin
                if (any_r) begin
                    m_phase = P_WAKE; m_elapsed = 1;
                end
            end
            P_WAKE: begin
                if (m_elapsed < WAKE_CYC) m_elapsed++;
                else if (any_r) m_phase = P_ON;
                else begin
                    m_phase = P_IDLE; m_elapsed = 1;
                end
            end
            P_ON: begin
                if (!any_r) begin
                    m_phase = P_IDLE; m_elapsed = 1;
                end
            end
            default: begin
                if (any_r) m_phase = P_ON;
                else if (m_elapsed >= IDLE_CYC) m_phase = P_OFF;
                else m_elapsed++;
            end
        endcase
    endtask

    // ---------------- driver tasks ----------------
    // Inputs are set at the falling edge; one rising edge is consumed per step.
    task automatic step();
        logic exp_clk;
        exp_clk = (m_phase != P_OFF);
        @(posedge clk_in);
        model_update();
        #2 chk("clk_out_high_phase", clk_out, exp_clk);
        @(negedge clk_in);
        chk("state", state_o, m_phase);
        chk("ack", ack, m_ack);
        chk("clk_en", clk_en, m_phase != P_OFF);
        chk("clk_out_low_phase", clk_out, 0);
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_state", state_o, P_OFF);
        chk("rst_ack", ack, 0);
        chk("rst_clk_en", clk_en, 0);
        chk("rst_clk_out", clk_out, 0);
        @(posedge clk_in);
        #2 chk("rst_clk_out_held", clk_out, 0);
        @(negedge clk_in);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic go_off();
        req = '0;
        force_on = 1'b0;
        repeat (IDLE_CYC + 2) step();
        chk("go_off_state", state_o, P_OFF);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [N_REQ-1:0] req;
        logic             force_on;
        logic [1:0]       st;
        logic [N_REQ-1:0] ack;
        logic             en;
    } vec_t;

    vec_t vecs [15];

    initial begin
        int r0;

        // Wake/grant then idle/gate-off with one requester.
        vecs[0]  = {4'b0001, 1'b0, 2'd1, 4'b0000, 1'b1};
        vecs[1]  = {4'b0001, 1'b0, 2'd1, 4'b0000, 1'b1};
        vecs[2]  = {4'b0001, 1'b0, 2'd2, 4'b0000, 1'b1};
        vecs[3]  = {4'b0001, 1'b0, 2'd2, 4'b0001, 1'b1};
        vecs[4]  = {4'b0001, 1'b0, 2'd2, 4'b0001, 1'b1};
        for (int i = 5; i < 13; i++) vecs[i] = {4'b0000, 1'b0, 2'd3, 4'b0000, 1'b1};
        vecs[13] = {4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0};
        vecs[14] = {4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0};

        rst_n    = 1'b0;
        req      = '0;
        force_on = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_in);
        chk("init_state", state_o, P_OFF);
        chk("init_ack", ack, 0);
        chk("init_clk_en", clk_en, 0);
        @(posedge clk_in);
        #2 chk("init_clk_out", clk_out, 0);
        @(negedge clk_in);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            req      = vecs[i].req;
            force_on = vecs[i].force_on;
            step();
            chk("tbl_state", state_o, vecs[i].st);
            chk("tbl_ack", ack, vecs[i].ack);
            chk("tbl_clk_en", clk_en, vecs[i].en);
        end
        r0 = rise_cnt;
        repeat (4) step();
        chk("off_no_pulse", rise_cnt - r0, 0);

        // Request during idle countdown returns to ON with no wake delay.
        req = 4'b0001;
        repeat (4) step();
        req = 4'b0000;
        repeat (5) step();
        chk("idle_mid_state", state_o, P_IDLE);
        req = 4'b0100;
        step();
        chk("idle_rereq_state", state_o, P_ON);
        chk("idle_rereq_ack0", ack, 0);
        step();
        chk("idle_rereq_ack", ack, 4'b0100);
        go_off();

        // Request on the exact expiry edge.
        req = 4'b0001;
        repeat (3) step();
        req = 4'b0000;
        repeat (IDLE_CYC) step();
        chk("expiry_pre_state", state_o, P_IDLE);
        req = 4'b0010;
        step();
        chk("expiry_state", state_o, P_ON);
        chk("expiry_clk_en", clk_en, 1);
        step();
        chk("expiry_ack", ack, 4'b0010);
        go_off();

        // Asynchronous reset while granted, then a full wake again.
        req = 4'b1010;
        repeat (4) step();
        chk("pre_rst_ack", ack, 4'b1010);
        reset_pulse();
        step();
        chk("post_rst_wake1", state_o, P_WAKE);
        step();
        chk("post_rst_wake2", state_o, P_WAKE);
        step();
        chk("post_rst_on", state_o, P_ON);
        step();
        chk("post_rst_ack", ack, 4'b1010);
        go_off();

        // force_on alone keeps the clock up without any grant.
        rst_n = 1'b0;
        model_reset();
        force_on = 1'b1;
        @(negedge clk_in);
        rst_n = 1'b1;
        repeat (4) step();
        chk("force_state", state_o, P_ON);
        chk("force_ack", ack, 0);
        force_on = 1'b0;
        repeat (IDLE_CYC) step();
        chk("force_idle_state", state_o, P_IDLE);
        step();
        chk("force_off_state", state_o, P_OFF);
        chk("force_off_clk_en", clk_en, 0);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0, 1: req = '0;
                    2: req = N_REQ'($urandom_range(1, 15));
                    default: req = req ^ (N_REQ'(1) << $urandom_range(0, N_REQ - 1));
                endcase
            end
            if ($urandom_range(0, 39) == 0) force_on = ~force_on;
            if ($urandom_range(0, 199) == 0) reset_pulse();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
